mk8_multi_interval_timer: RTL and testbench

//  Parametrised successor to the single-channel interval timer. Provides NUM_CH independent

---
 rtl/mk8_multi_interval_timer.sv | 81 ++++++++
 tb/tb_mk8_multi_interval_timer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mk8_multi_interval_timer.sv
// mk8_multi_interval_timer: NUM_CH prescaled down-counting interval timers with snapshot and IRQ on an Avalon-MM slave
module mk8_multi_interval_timer #(
  parameter int NUM_CH = 4,
  parameter int COUNT_W = 32,
  parameter int DEFAULT_PERIOD = 99999,
  localparam int ADDR_W = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);
  localparam logic [COUNT_W-1:0] DEF = COUNT_W'(DEFAULT_PERIOD);
  logic [ADDR_W-1:0] ch;
  logic [1:0] reg_sel;
  logic wr;
  logic [31:0] chan_rd [NUM_CH];
  logic [31:0] rd_next;
  assign ch = address >> 2;
  assign reg_sel = address[1:0];
  assign wr = chipselect && !write_n;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [COUNT_W-1:0] count, period, snap;
    logic [7:0] ps, psc;
    logic run, to, ito, cont, reload;
    logic sel, wr_stat, wr_ctrl, wr_per, wr_snap, start, stop, tick, expire;
    assign sel = wr && ch == ADDR_W'(g);
    assign wr_stat = sel && reg_sel == 2'd0;
    assign wr_ctrl = sel && reg_sel == 2'd1;
    assign wr_per = sel && reg_sel == 2'd2;
    assign wr_snap = sel && reg_sel == 2'd3;
    assign start = wr_ctrl && writedata[2];
    assign stop = wr_ctrl && writedata[3];
    assign tick = run && psc == 8'd0;
    assign expire = tick && count == '0;
    // reload is the one-cycle-delayed force reload that follows a PERIOD write
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        count <= DEF;
        period <= DEF;
        snap <= '0;
        ps <= '0;
        psc <= '0;
        run <= 1'b0;
        to <= 1'b0;
        ito <= 1'b0;
        cont <= 1'b0;
        reload <= 1'b0;
      end else begin
        if (wr_ctrl) begin
          ito <= writedata[0];
          cont <= writedata[1];
          ps <= writedata[15:8];
        end
        if (wr_per) period <= writedata[COUNT_W-1:0];
        if (wr_snap) snap <= count;
        reload <= wr_per;
        to <= expire || (to && !wr_stat);
        run <= reload ? 1'b0 : start ? 1'b1 : stop ? 1'b0 : (expire && !cont) ? 1'b0 : run;
        count <= (reload || expire) ? period : tick ? count - COUNT_W'(1) : count;
        psc <= start ? writedata[15:8] : (wr_per || tick) ? ps : run ? psc - 8'd1 : psc;
      end
    assign irq_vec[g] = to && ito;
    assign chan_rd[g] = reg_sel == 2'd0 ? {30'd0, run, to} :
                        reg_sel == 2'd1 ? {16'd0, ps, 6'd0, cont, ito} :
                        reg_sel == 2'd2 ? 32'(period) : 32'(snap);
  end
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NUM_CH; k++) if (ch == ADDR_W'(k)) rd_next = chan_rd[k];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) readdata <= '0;
    else readdata <= rd_next;
  assign irq = |irq_vec;
endmodule

// File: tb/tb_mk8_multi_interval_timer.sv
// tb_mk8_multi_interval_timer: scoreboarded register-level checks of the multi-channel interval timer
module tb_mk8_multi_interval_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0] irq_vec;
  logic irq;
  int checks = 0;
  int errors = 0;
  string tag_q[$];
  logic [31:0] exp_q[$];

  mk8_multi_interval_timer dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_vec(irq_vec), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] e);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    check(tag_q.pop_front(), readdata, exp_q.pop_front());
  endtask

  initial begin
    idle(2);
    check("rst readdata", readdata, 32'd0);
    check("rst irq", {31'd0, irq}, 32'd0);
    check("rst irq_vec", {28'd0, irq_vec}, 32'd0);
    reset = 1'b0;
    rd("ch0 period default", 4'd2, 32'd99999);
    rd("ch0 status rst", 4'd0, 32'd0);
    rd("ch0 control rst", 4'd1, 32'd0);
    // ch1: period 9, continuous, PS=0 -> timeout every 10 clks
    wr(4'd6, 32'd9);
    idle(1);
    wr(4'd5, 32'h0000_0007);
    idle(9);
    check("ch1 before 1st TO", {28'd0, irq_vec}, 32'h0);
    idle(1);
    check("ch1 1st TO", {28'd0, irq_vec}, 32'h2);
    check("ch1 irq", {31'd0, irq}, 32'd1);
    rd("ch1 status TO", 4'd4, 32'd3);
    wr(4'd4, 32'd0);
    check("ch1 irq cleared", {31'd0, irq}, 32'd0);
    idle(7);
    check("ch1 before 2nd TO", {28'd0, irq_vec}, 32'h0);
    idle(1);
    check("ch1 2nd TO", {28'd0, irq_vec}, 32'h2);
    rd("ch1 status run", 4'd4, 32'd3);
    wr(4'd5, 32'h0000_0008);
    wr(4'd4, 32'd0);
    check("ch1 stopped", {28'd0, irq_vec}, 32'h0);
    // ch2: period 3, PS=3, one-shot -> single timeout after 16 clks
    wr(4'd10, 32'd3);
    idle(1);
    wr(4'd9, 32'h0000_0305);
    idle(15);
    check("ch2 before TO", {28'd0, irq_vec}, 32'h0);
    idle(1);
    check("ch2 TO", {28'd0, irq_vec}, 32'h4);
    check("ch2 irq", {31'd0, irq}, 32'd1);
    rd("ch2 status oneshot", 4'd8, 32'd1);
    wr(4'd11, 32'd0);
    rd("ch2 count reloaded", 4'd11, 32'd3);
    rd("ch2 control readback", 4'd9, 32'h0000_0301);
    wr(4'd8, 32'd0);
    check("ch2 irq cleared", {31'd0, irq}, 32'd0);
    // ch0: snapshot while running, then PERIOD write forces reload and stop
    wr(4'd2, 32'd20);
    idle(1);
    wr(4'd1, 32'h0000_0006);
    idle(15);
    wr(4'd3, 32'd0);
    rd("ch0 snap 5", 4'd3, 32'd5);
    rd("ch0 snap held", 4'd3, 32'd5);
    wr(4'd2, 32'd50);
    idle(1);
    wr(4'd3, 32'd0);
    rd("ch0 forced reload", 4'd3, 32'd50);
    rd("ch0 status stopped", 4'd0, 32'd0);
    rd("ch0 period new", 4'd2, 32'd50);
    // ch3: clear TO on the exact timeout edge; set must win
    wr(4'd14, 32'd4);
    idle(1);
    wr(4'd13, 32'h0000_0007);
    idle(4);
    wr(4'd12, 32'd0);
    check("ch3 TO set wins", {28'd0, irq_vec}, 32'h8);
    rd("ch3 status set wins", 4'd12, 32'd3);
    wr(4'd13, 32'h0000_000B);
    rd("ch3 stopped", 4'd12, 32'd1);
    wr(4'd13, 32'h0000_000F);
    rd("ch3 start wins", 4'd12, 32'd3);
    check("pre-reset readdata", readdata, 32'd3);
    check("pre-reset irq", {31'd0, irq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async rst readdata", readdata, 32'd0);
    check("async rst irq", {31'd0, irq}, 32'd0);
    check("async rst irq_vec", {28'd0, irq_vec}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    rd("ch3 period after rst", 4'd14, 32'd99999);
    rd("ch3 status after rst", 4'd12, 32'd0);
    wr(4'd1, 32'hFFFF_FFFF);
    rd("ch0 control mask", 4'd1, 32'h0000_FF03);
    rd("ch0 start over stop", 4'd0, 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
